morse_gen_char: RTL and testbench

Morse character keyer: accepts one character as a length plus a dit/dah pattern, then drives a keyed `signal` line with mark and space durations taken from the same `dit_time`/`dah_time`/`word_time` inputs used by the capture side. It is the transmit counterpart of the character capture block. Its output can be looped straight into that block, and it must decode to the same `len`/`dits_dahs` values. The block sits between the character source (text-to-Morse lookup or test FIFO) and the physical key/LED/tone output. All timing advances only on `ce` ticks.

---
 rtl/morse_gen_char.sv | 174 +++++++++++++++++
 tb/tb_morse_gen_char.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_gen_char.sv
// Morse character keyer: turns a len/pattern pair into timed marks and spaces on `signal`.
// Define MORSE_GEN_LEN_CHECK_EN to reject len==0 or len>MAX_MORSE_LEN with an `err` pulse.

`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 4
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 8
`endif

module morse_gen_char (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic [`PULSE_CNT_W-1:0]   dit_time,
    input  logic [`PULSE_CNT_W-1:0]   dah_time,
    input  logic [`PULSE_CNT_W-1:0]   word_time,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [`MORSE_LEN_W-1:0]   in_len,
    input  logic [`MAX_MORSE_LEN-1:0] in_dits_dahs,
    input  logic                      in_word_end,
    output logic                      signal,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int CW    = `PULSE_CNT_W;
    localparam int LW    = `MORSE_LEN_W;
    localparam int ML    = `MAX_MORSE_LEN;
    localparam int IDX_W = (ML > 1) ? $clog2(ML) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_TAIL
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ML-1:0]     pat_q, pat_d;
    logic              word_q, word_d;
    logic              signal_q, signal_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [CW-1:0]     dit_f, dah_f, word_f, elem_t, tail_t;
    logic [LW-1:0]     eff_len;
    logic              len_bad;

    // Zero durations are floored to one tick so every phase lasts at least one ce.
    assign dit_f   = (dit_time  == '0) ? CW'(1) : dit_time;
    assign dah_f   = (dah_time  == '0) ? CW'(1) : dah_time;
    assign word_f  = (word_time == '0) ? CW'(1) : word_time;
    assign elem_t  = pat_q[idx_q] ? dah_f : dit_f;
    assign tail_t  = word_q ? word_f : dah_f;
    assign len_bad = (in_len == '0) || (in_len > LW'(ML));
    assign eff_len = (in_len > LW'(ML)) ? LW'(ML) : in_len;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        word_d   = word_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef MORSE_GEN_LEN_CHECK_EN
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
`else
                    begin
`endif
                        pat_d  = in_dits_dahs;
                        word_d = in_word_end;
                        cnt_d  = CW'(1);
                        if (in_len == '0) begin
                            idx_d   = '0;
                            state_d = ST_TAIL;
                        end else begin
                            idx_d   = IDX_W'(eff_len - LW'(1));
                            state_d = ST_MARK;
                        end
                    end
                end
            end

            ST_MARK: begin
                if (ce) begin
                    if (cnt_q >= elem_t) begin
                        cnt_d   = CW'(1);
                        state_d = (idx_q != '0) ? ST_SPACE : ST_TAIL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_SPACE: begin
                if (ce) begin
                    if (cnt_q >= dit_f) begin
                        cnt_d   = CW'(1);
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_MARK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_TAIL: begin
                if (ce) begin
                    if (cnt_q >= tail_t) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Registering from the next state makes the mark start on the accept edge itself.
    assign signal_d = (state_d == ST_MARK);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            pat_q    <= '0;
            word_q   <= 1'b0;
            signal_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            word_q   <= word_d;
            signal_q <= signal_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = ~in_ready;
    assign signal   = signal_q;
    assign done     = done_q;
`ifdef MORSE_GEN_LEN_CHECK_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_morse_gen_char.sv
// Scoreboard bench for morse_gen_char: stimulus pushes expected mark/gap/done events,
// a monitor reconstructs them from `signal`, `done` and `err` and compares in order.

`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 4
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 8
`endif

module tb_morse_gen_char;

    localparam int CW = `PULSE_CNT_W;
    localparam int LW = `MORSE_LEN_W;
    localparam int ML = `MAX_MORSE_LEN;

    typedef enum int { EV_LAT, EV_MARK, EV_GAP, EV_DONE, EV_ERR } ev_kind_t;
    typedef struct { ev_kind_t kind; int val; } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce;
    logic [CW-1:0] dit_time = CW'(2);
    logic [CW-1:0] dah_time = CW'(6);
    logic [CW-1:0] word_time = CW'(14);
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] in_len = '0;
    logic [ML-1:0] in_dits_dahs = '0;
    logic          in_word_end = 1'b0;
    logic          signal, busy, done, err;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  gate = 1'b0;

    morse_gen_char dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .dit_time     (dit_time),
        .dah_time     (dah_time),
        .word_time    (word_time),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_len       (in_len),
        .in_dits_dahs (in_dits_dahs),
        .in_word_end  (in_word_end),
        .signal       (signal),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign ce = gate ? ~cyc[0] : 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_t k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input ev_kind_t k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d, expected nothing (t=%0t)", k, v, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check("event_val", v, e.val);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active clock edge.
    initial begin
        int  high_run = 0;
        int  low_run  = 0;
        bit  in_gap   = 1'b0;
        bit  prev_sig = 1'b0;
        int  acc_cyc  = -1000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                high_run = 0;
                low_run  = 0;
                in_gap   = 1'b0;
                prev_sig = 1'b0;
                acc_cyc  = -1000;
            end else begin
                if (done) begin
                    got(EV_DONE, cyc - acc_cyc);
                    in_gap = 1'b0;
                end
                if (err) got(EV_ERR, cyc - acc_cyc);
                if (signal && !prev_sig) begin
                    if (in_gap) got(EV_GAP, low_run);
                    else        got(EV_LAT, cyc - acc_cyc);
                    in_gap   = 1'b0;
                    high_run = 0;
                end
                if (!signal && prev_sig) begin
                    got(EV_MARK, high_run);
                    in_gap  = 1'b1;
                    low_run = 0;
                end
                if (signal) high_run++;
                else        low_run++;
                if (busy !== ~in_ready) check("busy_vs_ready", int'(busy), int'(~in_ready));
                prev_sig = signal;
                if (in_valid && in_ready) acc_cyc = cyc + 1;
            end
        end
    end

    task automatic send(input int len, input logic [ML-1:0] pat, input logic we);
        bit acc = 1'b0;
        int n = 0;
        in_len       = LW'(len);
        in_dits_dahs = pat;
        in_word_end  = we;
        in_valid     = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, both while held and after release.
        #12;
        check("rst_signal", int'(signal), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_signal", int'(signal), 0);
        check("idle_ready", int'(in_ready), 1);

        // 'A': .-  -> 2 mark, 2 space, 6 mark, 6 tail, done at 16.
        push(EV_LAT, 0); push(EV_MARK, 2); push(EV_GAP, 2); push(EV_MARK, 6); push(EV_DONE, 16);
        send(2, ML'(2'b01), 1'b0);
        check("busy_after_accept", int'(busy), 1);
        drain();

        // 'E' with word end, then 'T' accepted in the done cycle.
        push(EV_LAT, 0); push(EV_MARK, 2); push(EV_DONE, 16);
        push(EV_LAT, 0); push(EV_MARK, 6); push(EV_DONE, 12);
        send(1, ML'(1'b0), 1'b1);
        send(1, ML'(1'b1), 1'b0);
        drain();

        // "SOS" back to back, word end on the last S.
        push(EV_LAT, 0); push(EV_MARK, 2); push(EV_GAP, 2); push(EV_MARK, 2); push(EV_GAP, 2);
        push(EV_MARK, 2); push(EV_DONE, 16);
        push(EV_LAT, 0); push(EV_MARK, 6); push(EV_GAP, 2); push(EV_MARK, 6); push(EV_GAP, 2);
        push(EV_MARK, 6); push(EV_DONE, 28);
        push(EV_LAT, 0); push(EV_MARK, 2); push(EV_GAP, 2); push(EV_MARK, 2); push(EV_GAP, 2);
        push(EV_MARK, 2); push(EV_DONE, 24);
        send(3, ML'(3'b000), 1'b0);
        send(3, ML'(3'b111), 1'b0);
        send(3, ML'(3'b000), 1'b1);
        drain();

        // 'A' with ce every second cycle: 4/4/12/12, done at 32.
        gate = 1'b1;
        while (cyc[0] != 1'b0) begin
            @(posedge clk);
            #1;
        end
        push(EV_LAT, 0); push(EV_MARK, 4); push(EV_GAP, 4); push(EV_MARK, 12); push(EV_DONE, 32);
        send(2, ML'(2'b01), 1'b0);
        drain();
        gate = 1'b0;

        // Reset in the middle of the dah of 'A'; no done may follow.
        push(EV_LAT, 0); push(EV_MARK, 2); push(EV_GAP, 2);
        send(2, ML'(2'b01), 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_signal", int'(signal), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_signal", int'(signal), 0);
        check("midrst_ready", int'(in_ready), 1);
        check("midrst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_queue", exp_q.size(), 0);
        push(EV_LAT, 0); push(EV_MARK, 2); push(EV_DONE, 16);
        send(1, ML'(1'b0), 1'b1);
        drain();

        // len==0 and len>MAX_MORSE_LEN boundaries.
`ifdef MORSE_GEN_LEN_CHECK_EN
        push(EV_ERR, 0);
        send(0, '0, 1'b0);
        drain();
        push(EV_ERR, 0);
        send(ML + 1, ML'(1) << (ML - 1), 1'b0);
        drain();
`else
        push(EV_DONE, 6);
        send(0, '0, 1'b0);
        drain();
        // Clamped to MAX_MORSE_LEN elements: one dah then dits.
        push(EV_LAT, 0); push(EV_MARK, 6);
        for (int i = 1; i < ML; i++) begin
            push(EV_GAP, 2); push(EV_MARK, 2);
        end
        push(EV_DONE, 6 + (ML - 1) * 4 + 6);
        send(ML + 1, ML'(1) << (ML - 1), 1'b0);
        drain();
`endif

        check("final_signal", int'(signal), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
